// File: rtl/morse_keyer.sv
// morse_keyer: conditions a raw mechanical Morse key into clean symbol events.
// Chain: two-flop synchroniser -> debouncer -> press timer (dot/dash) ->
// gap timer (letter/word close). Event outputs are decoded from registered
// state, so they are single-cycle and read 0 in the first cycle after reset.
module morse_keyer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DASH_MIN        = 15000000,
  parameter int LETTER_GAP      = 15000000,
  parameter int WORD_GAP        = 35000000,
  parameter int MAX_SYMBOLS     = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_in,
  output logic       key_level,
  output logic       dot_pulse,
  output logic       dash_pulse,
  output logic       letter_end,
  output logic       word_end,
  output logic [2:0] sym_count
);

  // Press and gap timers share one width; both saturate rather than wrap.
  localparam int CW = $clog2(WORD_GAP + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] DASH_MIN_C = CW'(DASH_MIN);
  localparam logic [CW-1:0] WORD_GAP_C = CW'(WORD_GAP);
  // gap_cnt is 0 in the cycle after the symbol pulse, so "N cycles after the
  // pulse" corresponds to gap_cnt == N-1.
  localparam logic [CW-1:0] LG_LAST    = CW'(LETTER_GAP - 1);
  localparam logic [CW-1:0] WG_LAST    = CW'(WORD_GAP - 1);
  localparam logic [DW-1:0] DB_ONE     = DW'(1);
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]    MAX_SYM_C  = 3'(MAX_SYMBOLS);
  localparam logic [2:0]    SYM_ONE    = 3'd1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } state_t;

  logic          sync_1_reg;
  logic          sync_2_reg;
  logic [DW-1:0] db_cnt_reg;
  logic          key_level_reg;

  state_t        state_reg, state_next;
  logic [CW-1:0] press_cnt_reg, press_cnt_next;
  logic [CW-1:0] gap_cnt_reg, gap_cnt_next;
  logic [2:0]    sym_count_reg, sym_count_next;
  logic          letter_done_reg, letter_done_next;

  // Two-flop synchroniser for the asynchronous key input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_1_reg <= 1'b0;
      sync_2_reg <= 1'b0;
    end else begin
      sync_1_reg <= key_in;
      sync_2_reg <= sync_1_reg;
    end
  end

  // Debouncer: level flips on the DEBOUNCE_CYCLES-th consecutive disagreeing
  // sample; any agreeing sample restarts the run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_cnt_reg    <= '0;
      key_level_reg <= 1'b0;
    end else if (sync_2_reg == key_level_reg) begin
      db_cnt_reg <= '0;
    end else if (db_cnt_reg == DB_LAST) begin
      db_cnt_reg    <= '0;
      key_level_reg <= ~key_level_reg;
    end else begin
      db_cnt_reg <= db_cnt_reg + DB_ONE;
    end
  end

  // FSM and timer state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      press_cnt_reg   <= '0;
      gap_cnt_reg     <= '0;
      sym_count_reg   <= '0;
      letter_done_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      press_cnt_reg   <= press_cnt_next;
      gap_cnt_reg     <= gap_cnt_next;
      sym_count_reg   <= sym_count_next;
      letter_done_reg <= letter_done_next;
    end
  end

  // Next-state and event decode. In IDLE/GAP a high key_level can only mean a
  // fresh press, because PRESS is left only once the level has dropped.
  always_comb begin
    state_next       = state_reg;
    press_cnt_next   = press_cnt_reg;
    gap_cnt_next     = gap_cnt_reg;
    sym_count_next   = sym_count_reg;
    letter_done_next = letter_done_reg;
    dot_pulse        = 1'b0;
    dash_pulse       = 1'b0;
    letter_end       = 1'b0;
    word_end         = 1'b0;

    case (state_reg)
      IDLE: begin
        if (key_level_reg) begin
          state_next       = PRESS;
          press_cnt_next   = CNT_ONE;
          letter_done_next = 1'b0;
        end
      end

      PRESS: begin
        if (key_level_reg) begin
          if (press_cnt_reg < DASH_MIN_C) begin
            press_cnt_next = press_cnt_reg + CNT_ONE;
          end
        end else begin
          if (press_cnt_reg < DASH_MIN_C) begin
            dot_pulse = 1'b1;
          end else begin
            dash_pulse = 1'b1;
          end
          sym_count_next = sym_count_reg + SYM_ONE;
          gap_cnt_next   = '0;
          state_next     = GAP;
        end
      end

      GAP: begin
        if (gap_cnt_reg < WORD_GAP_C) begin
          gap_cnt_next = gap_cnt_reg + CNT_ONE;
        end
        // A full letter closes immediately; the gap-timed close is then
        // suppressed for the rest of this gap.
        if (sym_count_reg == MAX_SYM_C) begin
          letter_end       = 1'b1;
          sym_count_next   = '0;
          letter_done_next = 1'b1;
        end else if (gap_cnt_reg == LG_LAST && sym_count_reg != 3'd0 &&
                     !letter_done_reg) begin
          letter_end     = 1'b1;
          sym_count_next = '0;
        end
        if (gap_cnt_reg == WG_LAST) begin
          word_end   = 1'b1;
          state_next = IDLE;
        end
        // A new press abandons the gap; an unclosed letter stays open.
        if (key_level_reg) begin
          state_next       = PRESS;
          press_cnt_next   = CNT_ONE;
          letter_done_next = 1'b0;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign key_level = key_level_reg;
  assign sym_count = sym_count_reg;

endmodule

// File: tb/tb_morse_keyer.sv
// tb_morse_keyer: directed scenarios plus randomized key activity, checked every
// cycle against a timeline model of the keyer, with literal timing checks.
module tb_morse_keyer;

  localparam int D  = 4;
  localparam int DM = 12;
  localparam int LG = 30;
  localparam int WG = 70;
  localparam int MS = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_in = 1'b0;
  logic       key_level;
  logic       dot_pulse;
  logic       dash_pulse;
  logic       letter_end;
  logic       word_end;
  logic [2:0] sym_count;

  always #5 clk = ~clk;

  morse_keyer #(
    .DEBOUNCE_CYCLES(D),
    .DASH_MIN(DM),
    .LETTER_GAP(LG),
    .WORD_GAP(WG),
    .MAX_SYMBOLS(MS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .key_in(key_in),
    .key_level(key_level),
    .dot_pulse(dot_pulse),
    .dash_pulse(dash_pulse),
    .letter_end(letter_end),
    .word_end(word_end),
    .sym_count(sym_count)
  );

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endfunction

  // ---------------- timeline model ----------------
  // hist holds raw key samples, one per clock edge; the debounced level flips
  // once the D samples that have passed the two sync stages all disagree.
  bit hist[$];
  bit m_level;
  int run_len;     // length of the current high run of the debounced level
  bit gap_open;    // a symbol was emitted and no press has followed yet
  int sym_time;    // model cycle of the last symbol pulse
  int nsym;        // symbols in the open letter
  bit done;        // letter already closed by the symbol limit
  int m_t;
  bit e_level, e_dot, e_dash, e_le, e_we;
  int e_sym;

  task automatic model_init();
    hist.delete();
    for (int i = 0; i < D + 2; i++) hist.push_back(1'b0);
    m_level = 0; run_len = 0; gap_open = 0; sym_time = 0;
    nsym = 0; done = 0; m_t = 0;
    e_level = 0; e_dot = 0; e_dash = 0; e_le = 0; e_we = 0; e_sym = 0;
  endtask

  task automatic model_step();
    bit prev;
    bit tog;
    int n;
    int d;
    prev = m_level;
    hist.push_back(key_in);
    n = hist.size();
    tog = 1'b1;
    for (int i = n - 2 - D; i <= n - 3; i++)
      if (hist[i] == m_level) tog = 1'b0;
    void'(hist.pop_front());
    if (tog) m_level = !m_level;
    m_t++;
    e_level = m_level;
    e_sym = nsym;
    e_dot = 0; e_dash = 0; e_le = 0; e_we = 0;
    if (prev && !m_level) begin
      // press just ended: classify by its length
      if (run_len >= DM) e_dash = 1; else e_dot = 1;
      nsym++;
      sym_time = m_t;
      gap_open = 1;
    end else if (gap_open) begin
      d = m_t - sym_time;
      if (d == 1 && nsym == MS) begin
        e_le = 1; nsym = 0; done = 1;
      end else if (d == LG && nsym > 0 && !done) begin
        e_le = 1; nsym = 0;
      end
      if (d == WG) begin
        e_we = 1; gap_open = 0;
      end
      if (m_level) gap_open = 0;
    end
    if (m_level) begin
      if (!prev) done = 0;
      run_len = prev ? run_len + 1 : 1;
    end
  endtask

  initial model_init();

  // Advance the model once per clock edge (reset clears it like the DUT).
  always @(posedge clk) begin
    if (reset) model_init();
    else model_step();
  end

  // ---------------- event recording for directed checks ----------------
  int dot_t[$], dash_t[$], le_t[$], we_t[$];
  int sym_after_pulse[$], sym_after_le[$];
  int level_hi;
  bit prev_pulse = 0, prev_le = 0;

  task automatic clear_stats();
    dot_t.delete(); dash_t.delete(); le_t.delete(); we_t.delete();
    sym_after_pulse.delete(); sym_after_le.delete();
    level_hi = 0;
  endtask

  // Per-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    chk("key_level", int'(key_level), int'(e_level));
    chk("dot_pulse", int'(dot_pulse), int'(e_dot));
    chk("dash_pulse", int'(dash_pulse), int'(e_dash));
    chk("letter_end", int'(letter_end), int'(e_le));
    chk("word_end", int'(word_end), int'(e_we));
    chk("sym_count", int'(sym_count), e_sym);
    if (prev_pulse) sym_after_pulse.push_back(int'(sym_count));
    if (prev_le) sym_after_le.push_back(int'(sym_count));
    if (dot_pulse) dot_t.push_back(cyc);
    if (dash_pulse) dash_t.push_back(cyc);
    if (letter_end) le_t.push_back(cyc);
    if (word_end) we_t.push_back(cyc);
    if (key_level) level_hi++;
    prev_pulse = dot_pulse | dash_pulse;
    prev_le = letter_end;
  end

  // Inputs change 1 time unit after the falling edge and hold for n edges.
  task automatic hold(bit v, int n);
    key_in = v;
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    clear_stats();
    repeat (3) @(negedge clk);
    #1;
    reset = 1'b0;

    // 1: short press -> dot, letter close at +30, word close at +70
    clear_stats();
    hold(1, 8); hold(0, 100);
    $display("scenario dot: dots=%0d letters=%0d words=%0d", dot_t.size(), le_t.size(), we_t.size());
    chk("s1 dot count", dot_t.size(), 1);
    chk("s1 dash count", dash_t.size(), 0);
    chk("s1 letter count", le_t.size(), 1);
    chk("s1 word count", we_t.size(), 1);
    chk("s1 sym after dot", (sym_after_pulse.size() > 0) ? sym_after_pulse[0] : -1, 1);
    chk("s1 letter delay", (le_t.size() > 0 && dot_t.size() > 0) ? le_t[0] - dot_t[0] : -1, LG);
    chk("s1 sym after letter", (sym_after_le.size() > 0) ? sym_after_le[0] : -1, 0);
    chk("s1 word delay", (we_t.size() > 0 && dot_t.size() > 0) ? we_t[0] - dot_t[0] : -1, WG);

    // 2: long press -> dash
    clear_stats();
    hold(1, 20); hold(0, 100);
    $display("scenario dash: dashes=%0d dots=%0d", dash_t.size(), dot_t.size());
    chk("s2 dash count", dash_t.size(), 1);
    chk("s2 dot count", dot_t.size(), 0);
    chk("s2 letter delay", (le_t.size() > 0 && dash_t.size() > 0) ? le_t[0] - dash_t[0] : -1, LG);
    chk("s2 word delay", (we_t.size() > 0 && dash_t.size() > 0) ? we_t[0] - dash_t[0] : -1, WG);

    // 3: bounce faster than the debounce window -> nothing at all
    clear_stats();
    for (int i = 0; i < 5; i++) begin
      hold(1, 2); hold(0, 2);
    end
    hold(0, 100);
    $display("scenario glitch: level_hi=%0d events=%0d", level_hi,
             dot_t.size() + dash_t.size() + le_t.size() + we_t.size());
    chk("s3 level high cycles", level_hi, 0);
    chk("s3 events", dot_t.size() + dash_t.size() + le_t.size() + we_t.size(), 0);

    // 4: five dots -> forced letter close right after the fifth
    clear_stats();
    for (int i = 0; i < 5; i++) begin
      hold(1, 6); hold(0, 10);
    end
    hold(0, 100);
    $display("scenario five dots: dots=%0d letters=%0d words=%0d", dot_t.size(), le_t.size(), we_t.size());
    chk("s4 dot count", dot_t.size(), 5);
    for (int i = 0; i < 5; i++)
      chk("s4 sym count step", (sym_after_pulse.size() > i) ? sym_after_pulse[i] : -1, i + 1);
    chk("s4 letter count", le_t.size(), 1);
    chk("s4 forced letter delay", (le_t.size() > 0 && dot_t.size() > 4) ? le_t[0] - dot_t[4] : -1, 1);
    chk("s4 sym after letter", (sym_after_le.size() > 0) ? sym_after_le[0] : -1, 0);
    chk("s4 word count", we_t.size(), 1);
    chk("s4 word delay", (we_t.size() > 0 && dot_t.size() > 4) ? we_t[0] - dot_t[4] : -1, WG);

    // 5: two dots 40 cycles apart -> two letters, one word
    clear_stats();
    hold(1, 8); hold(0, 40); hold(1, 8); hold(0, 120);
    $display("scenario two letters: dots=%0d letters=%0d words=%0d", dot_t.size(), le_t.size(), we_t.size());
    chk("s5 dot count", dot_t.size(), 2);
    chk("s5 letter count", le_t.size(), 2);
    chk("s5 letter1 delay", (le_t.size() > 0 && dot_t.size() > 0) ? le_t[0] - dot_t[0] : -1, LG);
    chk("s5 letter2 delay", (le_t.size() > 1 && dot_t.size() > 1) ? le_t[1] - dot_t[1] : -1, LG);
    chk("s5 word count", we_t.size(), 1);
    chk("s5 word delay", (we_t.size() > 0 && dot_t.size() > 1) ? we_t[0] - dot_t[1] : -1, WG);

    // 6: reset in the middle of a press discards it
    clear_stats();
    hold(1, 15);
    reset = 1'b1;
    hold(1, 3);
    hold(0, 3);
    reset = 1'b0;
    hold(0, 100);
    $display("scenario reset mid-press: dots=%0d dashes=%0d", dot_t.size(), dash_t.size());
    chk("s6 dot count", dot_t.size(), 0);
    chk("s6 dash count", dash_t.size(), 0);
    clear_stats();
    hold(1, 8); hold(0, 100);
    $display("scenario after reset: dots=%0d", dot_t.size());
    chk("s6 dot after reset", dot_t.size(), 1);
    chk("s6 sym after dot", (sym_after_pulse.size() > 0) ? sym_after_pulse[0] : -1, 1);

    // Randomized key activity checked by the per-cycle model
    for (int i = 0; i < 60; i++) begin
      int op;
      int ln;
      int gp;
      op = int'($urandom_range(0, 15));
      ln = int'($urandom_range(1, 25));
      gp = int'($urandom_range(1, 90));
      if (op == 0) begin
        reset = 1'b1;
        hold(key_in, int'($urandom_range(1, 4)));
        reset = 1'b0;
      end else if (op < 3) begin
        for (int j = 0; j < ln; j++) hold(bit'($urandom_range(0, 1)), 1);
      end
      hold(1, ln);
      hold(0, gp);
      $display("random txn %0d: op=%0d press=%0d release=%0d", i, op, ln, gp);
    end
    hold(0, 100);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/morse_keyer.md
Name: morse_keyer

Overview:
- Upstream front end of the Morse decoder. It turns one raw mechanical key into clean symbol events for the decoder to assemble.
- Processing chain: synchronise, debounce, time each press, classify it as dot or dash, time the silence between presses.
- Outputs: single-cycle dot/dash pulses, an end-of-letter pulse and an end-of-word pulse.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles needed before the debounced key changes level.
- DASH_MIN, 15000000: press length in cycles at or above which a press is a dash; shorter presses are dots.
- LETTER_GAP, 15000000: released cycles after a symbol that close the current letter.
- WORD_GAP, 35000000: released cycles after a symbol that close the current word. Must be greater than LETTER_GAP.
- MAX_SYMBOLS, 5: symbols per letter; reaching this count forces a letter close.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- key_in  input  1  raw key, asynchronous to clk, 1 = pressed.
- key_level  output  1  debounced key level.
- dot_pulse  output  1  one-cycle pulse per dot.
- dash_pulse  output  1  one-cycle pulse per dash.
- letter_end  output  1  one-cycle pulse when a letter closes.
- word_end  output  1  one-cycle pulse when a word closes.
- sym_count  output  3  symbols accepted in the current letter, 0..MAX_SYMBOLS.

Behaviour:
- Reset:
  - Asynchronous, active-high; takes effect immediately and overrides everything.
  - Clears both synchroniser flops, the debouncer, all counters and the FSM (to IDLE).
  - All outputs read 0 while reset is high and in the first cycle after release.
  - A key held through reset release is treated as a fresh press once debounced.
- Input conditioning:
  - key_in passes through a two-flop synchroniser.
  - The debouncer compares the synchronised value with key_level and counts consecutive differing cycles.
  - key_level toggles when that count reaches DEBOUNCE_CYCLES. Any agreeing cycle clears the count.
  - Result: clean edges appear on key_level 2+DEBOUNCE_CYCLES cycles after key_in.
- Counters:
  - press_cnt and gap_cnt are each sized by $clog2(WORD_GAP+1) and saturate; they never wrap.
- FSM state IDLE:
  - Waits for a key_level rising edge; on it, press_cnt=1 and the FSM moves to PRESS.
- FSM state PRESS:
  - press_cnt increments each cycle key_level is high, saturating at DASH_MIN. An arbitrarily long press is therefore a dash; there is no timeout.
  - The cycle after key_level falls:
    - dot_pulse=1 if press_cnt<DASH_MIN, otherwise dash_pulse=1. The two are never asserted together.
    - sym_count increments and gap_cnt=0.
    - The FSM moves to GAP.
- FSM state GAP:
  - gap_cnt increments each cycle, saturating at WORD_GAP.
  - Letter close:
    - letter_end fires exactly LETTER_GAP cycles after the symbol-pulse cycle, provided sym_count>0.
    - In the same cycle sym_count clears to 0.
  - Forced close:
    - If a symbol brings sym_count to MAX_SYMBOLS, letter_end fires on the next cycle and sym_count clears to 0.
    - A letter_done flag is then set, which suppresses the LETTER_GAP letter_end for that gap.
    - letter_done is cleared by the next key rising edge.
  - Word close:
    - word_end fires exactly WORD_GAP cycles after the symbol-pulse cycle; the FSM then returns to IDLE.
    - letter_end and word_end are never in the same cycle, because WORD_GAP>LETTER_GAP.
  - Key rising edge in GAP:
    - The FSM moves to PRESS with press_cnt=1 and gap_cnt is abandoned.
    - If LETTER_GAP has not yet elapsed, the letter stays open and sym_count keeps accumulating.
- Event ordering: dot_pulse/dash_pulse, letter_end and word_end are mutually exclusive in any single cycle.
- Glitches: a glitch shorter than DEBOUNCE_CYCLES produces no event.

Test Plan:
- All scenarios use DEBOUNCE_CYCLES=4, DASH_MIN=12, LETTER_GAP=30, WORD_GAP=70, MAX_SYMBOLS=5.
- Reset, then key_in high 8 cycles, then low -> one dot_pulse and no dash_pulse; sym_count=1. letter_end 30 cycles after the dot with sym_count=0. word_end 70 cycles after the dot. No other pulses.
- Key high 20 cycles, then low -> one dash_pulse. letter_end at +30, word_end at +70.
- Key toggling every 2 cycles for 20 cycles, then low -> key_level stays 0; no pulses of any kind; sym_count=0.
- Five 6-cycle presses separated by 10-cycle releases -> five dot_pulses, sym_count counting 1..5. letter_end one cycle after the 5th dot, sym_count back to 0. No letter_end at +30. word_end at +70 after the 5th dot.
- Dot, 40-cycle release, dot, then idle -> letter_end 30 cycles after each dot (two total). Exactly one word_end, 70 cycles after the second dot.
- Key high; reset asserted at press cycle 15; key released while reset is high; reset released -> all outputs 0 throughout. No dot or dash is emitted afterwards. A subsequent 8-cycle press yields a normal dot with sym_count=1.
